adc_capture_fifo: RTL and testbench

Drives the 8-bit parallel ADC clock (adc_clk) and samples adc_in. Packs sample pairs into 16-bit words and buffers them in a small first-word-fall-through (FWFT) FIFO. Presents the words on a valid/ready stream to the UART/Pi/SDRAM controller, which writes them to SDRAM. Capture is started by an arm pulse, is bounded by a word count, and can optionally be gated by a level trigger.

---
 rtl/adc_capture_fifo_if.sv | 9 +
 rtl/adc_capture_fifo.sv | 199 +++++++++++++++++++
 tb/tb_adc_capture_fifo.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_capture_fifo_if.sv
// Output stream of adc_capture_fifo: 16-bit words on a valid/ready handshake.
interface adc_capture_fifo_if;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/adc_capture_fifo.sv
// ADC capture: divides sys_clk into adc_clk, packs sample pairs into 16-bit words, buffers in a FWFT FIFO.
// Define ADC_CAPTURE_TRIG_EN to enable the rising-crossing level trigger (WAIT_TRIG state).
module adc_capture_fifo #(
  parameter int CLK_DIV = 2,
  parameter int FIFO_AW = 4,
  parameter int CNT_W   = 24
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [7:0]           adc_in,
  output logic                 adc_clk,
  input  logic                 arm,
  input  logic                 abort,
  input  logic [CNT_W-1:0]     sample_count,
  input  logic [7:0]           trig_level,
  adc_capture_fifo_if.master   out_if,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DEPTH = 2 ** FIFO_AW;

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef ADC_CAPTURE_TRIG_EN
    S_WAIT_TRIG,
`endif
    S_CAPTURE,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic               adc_clk_q, adc_clk_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic               phase_q, phase_d;
  logic [7:0]         low_q, low_d;
  logic               overflow_q, overflow_d;
  logic [FIFO_AW:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0]   rd_ptr_q, rd_ptr_d;
  logic [15:0]        mem_q [DEPTH];

  logic               wrap;
  logic               strobe;
  logic               empty;
  logic               full;
  logic               pop;
  logic               push_req;
  logic               push_ok;
  logic [15:0]        push_word;

`ifdef ADC_CAPTURE_TRIG_EN
  logic [7:0]         prev_q, prev_d;
  logic               trig_hit;
  assign trig_hit = (prev_q < trig_level) && (adc_in >= trig_level);
`else
  logic               unused_trig;
  assign unused_trig = ^trig_level;
`endif

  assign wrap   = (div_cnt_q == DIV_W'(CLK_DIV - 1));
  assign strobe = wrap && adc_clk_q;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                 (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign pop   = !empty && out_if.out_ready;

  assign push_word = {adc_in, low_q};

  assign out_if.out_valid = !empty;
  assign out_if.out_data  = mem_q[rd_ptr_q[FIFO_AW-1:0]];

  assign adc_clk  = adc_clk_q;
  assign overflow = overflow_q;
  assign done     = (state_q == S_DONE);
  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q + DIV_W'(1);
    adc_clk_d  = adc_clk_q;
    word_cnt_d = word_cnt_q;
    phase_d    = phase_q;
    low_d      = low_q;
    overflow_d = overflow_q;
    push_req   = 1'b0;
`ifdef ADC_CAPTURE_TRIG_EN
    prev_d     = prev_q;
`endif

    if (wrap) begin
      div_cnt_d = '0;
      adc_clk_d = !adc_clk_q;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (arm) begin
          word_cnt_d = sample_count;
          overflow_d = 1'b0;
          phase_d    = 1'b0;
`ifdef ADC_CAPTURE_TRIG_EN
          prev_d     = 8'hFF;
          state_d    = S_WAIT_TRIG;
`else
          state_d    = S_CAPTURE;
`endif
        end
      end
`ifdef ADC_CAPTURE_TRIG_EN
      S_WAIT_TRIG: begin
        if (word_cnt_q == '0) begin
          state_d = S_DONE;
        end else if (strobe) begin
          prev_d = adc_in;
          if (trig_hit) begin
            low_d   = adc_in;
            phase_d = 1'b1;
            state_d = S_CAPTURE;
          end
        end
      end
`endif
      S_CAPTURE: begin
        if (word_cnt_q == '0) begin
          state_d = S_DONE;
        end else if (strobe) begin
          if (!phase_q) begin
            low_d   = adc_in;
            phase_d = 1'b1;
          end else begin
            phase_d    = 1'b0;
            push_req   = 1'b1;
            word_cnt_d = word_cnt_q - CNT_W'(1);
            if (word_cnt_q == CNT_W'(1)) state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (empty) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    push_ok = push_req && (!full || pop);
    if (push_req && !push_ok) overflow_d = 1'b1;

    wr_ptr_d = push_ok ? wr_ptr_q + (FIFO_AW+1)'(1) : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + (FIFO_AW+1)'(1) : rd_ptr_q;

    if (abort) begin
      state_d    = S_IDLE;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      phase_d    = 1'b0;
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= S_IDLE;
      div_cnt_q  <= '0;
      adc_clk_q  <= 1'b0;
      word_cnt_q <= '0;
      phase_q    <= 1'b0;
      low_q      <= '0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
`ifdef ADC_CAPTURE_TRIG_EN
      prev_q     <= '1;
`endif
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      adc_clk_q  <= adc_clk_d;
      word_cnt_q <= word_cnt_d;
      phase_q    <= phase_d;
      low_q      <= low_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
`ifdef ADC_CAPTURE_TRIG_EN
      prev_q     <= prev_d;
`endif
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push_ok) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= push_word;
  end

endmodule

// File: tb/tb_adc_capture_fifo.sv
// Scoreboard bench for adc_capture_fifo: directed ADC sequences, expected words queued, monitor pops and compares.
module tb_adc_capture_fifo;

  localparam int CNT_W = 24;

  logic             sys_clk = 1'b0;
  logic             sys_rst_n = 1'b0;
  logic [7:0]       adc_in = 8'h00;
  logic             adc_clk;
  logic             arm = 1'b0;
  logic             abort = 1'b0;
  logic [CNT_W-1:0] sample_count = '0;
  logic [7:0]       trig_level = 8'h80;
  logic             busy, done, overflow;

  adc_capture_fifo_if sif();

  adc_capture_fifo #(.CLK_DIV(2), .FIFO_AW(4), .CNT_W(CNT_W)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .adc_in       (adc_in),
    .adc_clk      (adc_clk),
    .arm          (arm),
    .abort        (abort),
    .sample_count (sample_count),
    .trig_level   (trig_level),
    .out_if       (sif),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow)
  );

  always #5 sys_clk = !sys_clk;

  int          checks = 0;
  int          failures = 0;
  int          pops = 0;
  int          cyc = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  seq[$];
  int          pop_cyc[$];

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge sys_clk) begin
    if (sys_rst_n && sif.out_valid && sif.out_ready) begin
      pops++;
      pop_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word got=%0h exp=none", sif.out_data);
      end else begin
        check("stream_word", {16'h0, sif.out_data}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic arm_and_feed(input logic [CNT_W-1:0] cnt);
    @(negedge adc_clk);
    #1;
    adc_in = seq.pop_front();
    sample_count = cnt;
    arm = 1'b1;
    @(posedge sys_clk);
    #1;
    arm = 1'b0;
    while (seq.size() > 0) begin
      @(negedge adc_clk);
      #1;
      adc_in = seq.pop_front();
    end
  endtask

  task automatic wait_done(input string name, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge sys_clk);
      #1;
      if (done) break;
    end
    check(name, {31'h0, done}, 32'h1);
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(posedge sys_clk);
    #1;
    abort = 1'b0;
  endtask

  initial begin
    sif.out_ready = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_adc_clk", {31'h0, adc_clk}, 0);
    check("rst_valid", {31'h0, sif.out_valid}, 0);
    check("rst_busy", {31'h0, busy}, 0);
    check("rst_done", {31'h0, done}, 0);
    check("rst_overflow", {31'h0, overflow}, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (4) @(posedge sys_clk);

`ifdef ADC_CAPTURE_TRIG_EN
    // Trigger on rising crossing of 0x80; the initial 0x90 must not fire
    trig_level = 8'h80;
    seq = '{8'h90, 8'h70, 8'h7F, 8'h80, 8'h81, 8'h82, 8'h83};
    exp_q.push_back(16'h8180);
    exp_q.push_back(16'h8382);
    pops = 0;
    arm_and_feed(2);
    check("trig_busy", {31'h0, busy}, 1);
    wait_done("trig_done", 100);
    check("trig_pops", pops, 2);
    check("trig_queue_empty", exp_q.size(), 0);
`else
    // Ramp, 4 words, consumer always ready
    seq = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
    exp_q.push_back(16'h1110);
    exp_q.push_back(16'h1312);
    exp_q.push_back(16'h1514);
    exp_q.push_back(16'h1716);
    pops = 0;
    pop_cyc.delete();
    arm_and_feed(4);
    check("ramp_busy", {31'h0, busy}, 1);
    wait_done("ramp_done", 100);
    check("ramp_pops", pops, 4);
    check("ramp_overflow", {31'h0, overflow}, 0);
    if (pop_cyc.size() == 4) begin
      for (int i = 1; i < 4; i++) check("ramp_spacing", pop_cyc[i] - pop_cyc[i-1], 8);
    end else begin
      check("ramp_pop_log", pop_cyc.size(), 4);
    end

    // Consumer stalled: 20 words requested, only 16 fit
    sif.out_ready = 1'b0;
    for (int i = 0; i < 40; i++) seq.push_back(8'(i));
    for (int k = 0; k < 16; k++) exp_q.push_back({8'(2*k+1), 8'(2*k)});
    pops = 0;
    arm_and_feed(20);
    repeat (8) @(posedge sys_clk);
    #1;
    check("ovf_flag", {31'h0, overflow}, 1);
    check("ovf_busy", {31'h0, busy}, 1);
    check("ovf_valid", {31'h0, sif.out_valid}, 1);
    check("ovf_not_done", {31'h0, done}, 0);
    sif.out_ready = 1'b1;
    wait_done("ovf_done", 100);
    check("ovf_pops", pops, 16);
    check("ovf_queue_empty", exp_q.size(), 0);

    // Abort from DONE keeps the sticky overflow
    pulse_abort();
    check("abort_done_clear", {31'h0, done}, 0);
    check("abort_ovf_kept", {31'h0, overflow}, 1);

    // Zero-length capture
    sample_count = '0;
    arm = 1'b1;
    @(posedge sys_clk);
    #1;
    arm = 1'b0;
    check("zero_busy", {31'h0, busy}, 1);
    check("zero_done_early", {31'h0, done}, 0);
    @(posedge sys_clk);
    #1;
    check("zero_done", {31'h0, done}, 1);
    check("zero_valid", {31'h0, sif.out_valid}, 0);
    check("zero_ovf_cleared", {31'h0, overflow}, 0);

    // Abort mid-capture with 3 words buffered and a low byte pending
    sif.out_ready = 1'b0;
    seq = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
    arm_and_feed(8);
    @(negedge adc_clk);
    #1;
    check("pre_abort_valid", {31'h0, sif.out_valid}, 1);
    check("pre_abort_busy", {31'h0, busy}, 1);
    pulse_abort();
    check("abort_valid", {31'h0, sif.out_valid}, 0);
    check("abort_busy", {31'h0, busy}, 0);
    check("abort_done", {31'h0, done}, 0);
    sif.out_ready = 1'b1;
    seq = '{8'h50, 8'h51, 8'h52, 8'h53};
    exp_q.push_back(16'h5150);
    exp_q.push_back(16'h5352);
    pops = 0;
    arm_and_feed(2);
    wait_done("rearm_done", 100);
    check("rearm_pops", pops, 2);

    // Asynchronous reset while draining
    sif.out_ready = 1'b0;
    seq = '{8'h60, 8'h61, 8'h62, 8'h63};
    arm_and_feed(2);
    @(negedge adc_clk);
    #1;
    check("drain_busy", {31'h0, busy}, 1);
    check("drain_valid", {31'h0, sif.out_valid}, 1);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    check("arst_valid", {31'h0, sif.out_valid}, 0);
    check("arst_busy", {31'h0, busy}, 0);
    check("arst_done", {31'h0, done}, 0);
    check("arst_adc_clk", {31'h0, adc_clk}, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    begin
      time t_rel, t1, t2;
      t_rel = $time;
      @(posedge adc_clk);
      t1 = $time;
      @(posedge adc_clk);
      t2 = $time;
      check("arst_first_rise", 32'(t1 - t_rel), 15);
      check("arst_adc_period", 32'(t2 - t1), 40);
    end
    sif.out_ready = 1'b1;
    #1;
    check("arst_fifo_empty", {31'h0, sif.out_valid}, 0);
`endif

    repeat (4) @(posedge sys_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
